// File: rtl/midi_msg_scheduler_pkg.sv
// midi_pkg: MIDI status constants, message struct, arbiter state and
// byte-classification helpers shared by midi_msg_scheduler and its assemblers.
package midi_pkg;

    localparam logic [7:0] NOTE_OFF = 8'h80;
    localparam logic [7:0] NOTE_ON  = 8'h90;
    localparam logic [7:0] CC       = 8'hB0;
    localparam logic [7:0] PROG     = 8'hC0;
    localparam logic [7:0] SYSEX    = 8'hF0;
    localparam logic [7:0] EOX      = 8'hF7;
    localparam logic [7:0] CLOCK    = 8'hF8;

    // One assembled message as it travels from holding register to output.
    typedef struct packed {
        logic [7:0] status;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [1:0] len;
    } midi_msg_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OFFER = 1'b1
    } arb_state_t;

    // Number of data bytes that follow a status byte (0 for F6 and non-message bytes).
    function automatic logic [1:0] midi_data_len(input logic [7:0] status);
        logic [1:0] n;
        n = 2'd0;
        case (status[7:4])
            4'h8, 4'h9, 4'hA, 4'hB, 4'hE: n = 2'd2;
            4'hC, 4'hD:                   n = 2'd1;
            4'hF: begin
                case (status[3:0])
                    4'h1, 4'h3: n = 2'd1;
                    4'h2:       n = 2'd2;
                    default:    n = 2'd0;
                endcase
            end
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    // F8..FF are real-time bytes that may appear anywhere in the stream.
    function automatic logic is_realtime(input logic [7:0] b);
        return b[7:3] == 5'b11111;
    endfunction

endpackage

// File: rtl/midi_msg_scheduler_assembler.sv
// midi_msg_assembler: per-port MIDI message assembly with running status,
// sysex tracking and a one-deep holding register.
// MIDI_SYSRT_EN: when defined, real-time bytes are forwarded as a registered
// pulse; otherwise they are discarded here and rt_stb/rt_byte are tied 0.
module midi_msg_assembler
    import midi_pkg::*;
(
    input  logic       CLOCK_25,
    input  logic       iRST,
    input  logic       byte_stb,
    input  logic [7:0] byte_in,
    input  logic       hold_pop,
    output logic       hold_valid,
    output midi_msg_t  hold_msg,
    output logic       rt_stb,
    output logic [7:0] rt_byte,
    output logic       ovf
);

    logic [7:0] rs;
    logic       cnt;
    logic [7:0] d1;
    logic       in_sysex;

    logic [7:0] rs_nxt;
    logic       cnt_nxt;
    logic [7:0] d1_nxt;
    logic       sysex_nxt;
    logic       done;
    midi_msg_t  done_msg;

    // Classify the incoming byte and work out the next parser state and any completed message.
    always_comb begin
        rs_nxt    = rs;
        cnt_nxt   = cnt;
        d1_nxt    = d1;
        sysex_nxt = in_sysex;
        done      = 1'b0;
        done_msg  = '0;
        if (byte_stb && !is_realtime(byte_in)) begin
            if (!byte_in[7]) begin
                // Data: ignored inside sysex or without a status to attach to.
                if (!in_sysex && rs != 8'h00) begin
                    if (!cnt && midi_data_len(rs) == 2'd2) begin
                        d1_nxt  = byte_in;
                        cnt_nxt = 1'b1;
                    end else begin
                        done            = 1'b1;
                        done_msg.status = rs;
                        done_msg.len    = midi_data_len(rs);
                        if (cnt) begin
                            done_msg.d1 = d1;
                            done_msg.d2 = byte_in;
                        end else begin
                            done_msg.d1 = byte_in;
                        end
                        cnt_nxt = 1'b0;
                        // System common has no running status.
                        if (rs[7:4] == 4'hF)
                            rs_nxt = 8'h00;
                    end
                end
            end else if (byte_in == SYSEX) begin
                sysex_nxt = 1'b1;
                rs_nxt    = 8'h00;
            end else if (byte_in == EOX) begin
                sysex_nxt = 1'b0;
            end else if (byte_in[7:4] != 4'hF) begin
                rs_nxt  = byte_in;
                cnt_nxt = 1'b0;
            end else if (midi_data_len(byte_in) == 2'd0) begin
                // F4/F5 undefined, F6 tune request completes on its own.
                rs_nxt  = 8'h00;
                cnt_nxt = 1'b0;
                if (byte_in == 8'hF6) begin
                    done            = 1'b1;
                    done_msg.status = byte_in;
                end
            end else begin
                // F1/F2/F3: replaces channel running status until its data arrives.
                rs_nxt  = byte_in;
                cnt_nxt = 1'b0;
            end
        end
    end

    // Parser state, holding register and sticky overflow.
    always_ff @(posedge CLOCK_25) begin
        if (iRST) begin
            rs         <= '0;
            cnt        <= 1'b0;
            d1         <= '0;
            in_sysex   <= 1'b0;
            hold_valid <= 1'b0;
            hold_msg   <= '0;
            ovf        <= 1'b0;
        end else begin
            rs       <= rs_nxt;
            cnt      <= cnt_nxt;
            d1       <= d1_nxt;
            in_sysex <= sysex_nxt;
            if (done && hold_valid && !hold_pop) begin
                ovf <= 1'b1;
            end else if (done) begin
                hold_msg   <= done_msg;
                hold_valid <= 1'b1;
            end else if (hold_pop) begin
                hold_valid <= 1'b0;
            end
        end
    end

`ifdef MIDI_SYSRT_EN
    // One-cycle real-time pulse, one cycle after the strobe.
    always_ff @(posedge CLOCK_25) begin
        if (iRST) begin
            rt_stb  <= 1'b0;
            rt_byte <= '0;
        end else begin
            rt_stb <= byte_stb && is_realtime(byte_in);
            if (byte_stb && is_realtime(byte_in))
                rt_byte <= byte_in;
        end
    end
`else
    assign rt_stb  = 1'b0;
    assign rt_byte = '0;
`endif

endmodule

// File: rtl/midi_msg_scheduler.sv
// midi_msg_scheduler: two MIDI byte sources assembled independently and
// shared onto one downstream event interface round-robin; real-time bytes
// bypass on their own strobe.
// MIDI_SYSRT_EN: when defined, enables the real-time path and its one-entry
// skid for port 1; otherwise rt_stb/rt_byte are tied 0.
module midi_msg_scheduler
    import midi_pkg::*;
#(
    parameter int NPORTS = 2
) (
    input  logic                   CLOCK_25,
    input  logic                   iRST,
    input  logic [NPORTS-1:0]      byte_stb,
    input  logic [NPORTS-1:0][7:0] byte_in,
    output logic                   msg_valid,
    input  logic                   msg_ready,
    output logic [7:0]             msg_status,
    output logic [7:0]             msg_d1,
    output logic [7:0]             msg_d2,
    output logic [1:0]             msg_len,
    output logic                   msg_src,
    output logic                   rt_stb,
    output logic [7:0]             rt_byte,
    output logic [NPORTS-1:0]      ovf
);

    logic [NPORTS-1:0]            hold_valid;
    logic [NPORTS-1:0]            hold_pop;
    midi_msg_t [NPORTS-1:0]       hold_msg;
    logic [NPORTS-1:0]            asm_rt_stb;
    logic [NPORTS-1:0][7:0]       asm_rt_byte;
    logic [NPORTS-1:0]            asm_ovf;

    generate
        for (genvar g = 0; g < NPORTS; g++) begin : g_asm
            midi_msg_assembler u_asm (
                .CLOCK_25   (CLOCK_25),
                .iRST       (iRST),
                .byte_stb   (byte_stb[g]),
                .byte_in    (byte_in[g]),
                .hold_pop   (hold_pop[g]),
                .hold_valid (hold_valid[g]),
                .hold_msg   (hold_msg[g]),
                .rt_stb     (asm_rt_stb[g]),
                .rt_byte    (asm_rt_byte[g]),
                .ovf        (asm_ovf[g])
            );
        end
    endgenerate

    arb_state_t state, state_nxt;
    logic       rr_ptr;
    logic       grant;

    // Arbiter state register.
    always_ff @(posedge CLOCK_25) begin
        if (iRST)
            state <= ARB_IDLE;
        else
            state <= state_nxt;
    end

    // Arbiter next state: offer as soon as anything is held, release on handshake.
    always_comb begin
        state_nxt = state;
        if (state == ARB_IDLE) begin
            if (|hold_valid)
                state_nxt = ARB_OFFER;
        end else begin
            if (msg_ready)
                state_nxt = ARB_IDLE;
        end
    end

    // Arbiter outputs: favoured port if it has something, else the other one.
    always_comb begin
        hold_pop  = '0;
        msg_valid = (state == ARB_OFFER);
        grant     = hold_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
        if (state == ARB_IDLE && (|hold_valid))
            hold_pop[grant] = 1'b1;
    end

    // Output register and round-robin pointer.
    always_ff @(posedge CLOCK_25) begin
        if (iRST) begin
            msg_status <= '0;
            msg_d1     <= '0;
            msg_d2     <= '0;
            msg_len    <= '0;
            msg_src    <= 1'b0;
            rr_ptr     <= 1'b0;
        end else begin
            if (|hold_pop) begin
                msg_status <= hold_msg[grant].status;
                msg_d1     <= hold_msg[grant].d1;
                msg_d2     <= hold_msg[grant].d2;
                msg_len    <= hold_msg[grant].len;
                msg_src    <= grant;
            end
            if (state == ARB_OFFER && msg_ready)
                rr_ptr <= ~msg_src;
        end
    end

`ifdef MIDI_SYSRT_EN
    logic       skid_v;
    logic [7:0] skid_byte;
    logic       rt_ovf;

    // Port 0 real-time always goes out at once; port 1 waits in the skid behind it.
    always_ff @(posedge CLOCK_25) begin
        if (iRST) begin
            skid_v    <= 1'b0;
            skid_byte <= '0;
            rt_ovf    <= 1'b0;
        end else if (asm_rt_stb[0]) begin
            if (asm_rt_stb[1]) begin
                if (skid_v) begin
                    rt_ovf <= 1'b1;
                end else begin
                    skid_v    <= 1'b1;
                    skid_byte <= asm_rt_byte[1];
                end
            end
        end else if (skid_v) begin
            // Skid drains this cycle; a fresh port 1 byte takes its place.
            skid_v    <= asm_rt_stb[1];
            skid_byte <= asm_rt_byte[1];
        end
    end

    // Real-time output mux: port 0, then skid, then direct port 1.
    always_comb begin
        rt_stb  = (|asm_rt_stb) || skid_v;
        rt_byte = '0;
        if (asm_rt_stb[0])
            rt_byte = asm_rt_byte[0];
        else if (skid_v)
            rt_byte = skid_byte;
        else if (asm_rt_stb[1])
            rt_byte = asm_rt_byte[1];
    end

    assign ovf = {asm_ovf[1] | rt_ovf, asm_ovf[0]};
`else
    // Assemblers tie their real-time outputs low in this build.
    assign rt_stb  = |asm_rt_stb;
    assign rt_byte = asm_rt_byte[0] | asm_rt_byte[1];
    assign ovf     = asm_ovf;
`endif

endmodule

// File: tb/tb_midi_msg_scheduler.sv
// Directed bench for midi_msg_scheduler; expected messages are hand-computed.
module tb_midi_msg_scheduler;

    logic            CLOCK_25 = 1'b0;
    logic            iRST;
    logic [1:0]      byte_stb;
    logic [1:0][7:0] byte_in;
    logic            msg_valid;
    logic            msg_ready;
    logic [7:0]      msg_status;
    logic [7:0]      msg_d1;
    logic [7:0]      msg_d2;
    logic [1:0]      msg_len;
    logic            msg_src;
    logic            rt_stb;
    logic [7:0]      rt_byte;
    logic [1:0]      ovf;

    int n_vec = 0;
    int n_err = 0;

    always #20 CLOCK_25 = ~CLOCK_25;

    midi_msg_scheduler #(.NPORTS(2)) dut (
        .CLOCK_25   (CLOCK_25),
        .iRST       (iRST),
        .byte_stb   (byte_stb),
        .byte_in    (byte_in),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .msg_status (msg_status),
        .msg_d1     (msg_d1),
        .msg_d2     (msg_d2),
        .msg_len    (msg_len),
        .msg_src    (msg_src),
        .rt_stb     (rt_stb),
        .rt_byte    (rt_byte),
        .ovf        (ovf)
    );

    logic [31:0] out_pk;
    logic [31:0] rt_pk;
    assign out_pk = {5'b0, msg_status, msg_d1, msg_d2, msg_len, msg_src};
    assign rt_pk  = {23'b0, rt_stb, rt_byte};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic [7:0] s, input logic [7:0] a,
                                       input logic [7:0] b, input logic [1:0] l,
                                       input logic src);
        return {5'b0, s, a, b, l, src};
    endfunction

    // Called at a negedge; strobe is sampled by the next posedge, returns at the following negedge.
    task automatic send(input int p, input logic [7:0] b);
        byte_stb    = '0;
        byte_stb[p] = 1'b1;
        byte_in[p]  = b;
        @(negedge CLOCK_25);
        byte_stb = '0;
    endtask

    task automatic send2(input logic [7:0] b0, input logic [7:0] b1);
        byte_stb   = 2'b11;
        byte_in[0] = b0;
        byte_in[1] = b1;
        @(negedge CLOCK_25);
        byte_stb = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLOCK_25);
    endtask

    // Wait (bounded) for an offer, compare it, and let it transfer (msg_ready must be 1).
    task automatic expect_msg(input string tag, input logic [31:0] exp);
        int k;
        k = 0;
        while (!msg_valid && k < 20) begin
            @(negedge CLOCK_25);
            k++;
        end
        if (!msg_valid)
            chk({tag, "_timeout"}, {31'b0, msg_valid}, 32'd1);
        else
            chk(tag, out_pk, exp);
        @(negedge CLOCK_25);
    endtask

    initial begin
        iRST      = 1'b1;
        byte_stb  = '0;
        byte_in   = '0;
        msg_ready = 1'b0;
        idle(3);
        chk("rst_valid", {31'b0, msg_valid}, 32'd0);
        chk("rst_msg",   out_pk, 32'd0);
        chk("rst_rt",    rt_pk,  32'd0);
        chk("rst_ovf",   {30'b0, ovf}, 32'd0);
        iRST = 1'b0;
        msg_ready = 1'b1;
        idle(1);

        // Note on, latency check
        send(0, 8'h90); send(0, 8'h3C); send(0, 8'h64);
        chk("t1_lat_n1", {31'b0, msg_valid}, 32'd0);
        @(negedge CLOCK_25);
        chk("t1_lat_n2", {31'b0, msg_valid}, 32'd1);
        chk("t1_msg",    out_pk, pk(8'h90, 8'h3C, 8'h64, 2'd2, 1'b0));
        @(negedge CLOCK_25);
        chk("t1_done",   {31'b0, msg_valid}, 32'd0);

        // Running status on port 1
        send(1, 8'hB0); send(1, 8'h07); send(1, 8'h7F);
        expect_msg("t2_msg_a", pk(8'hB0, 8'h07, 8'h7F, 2'd2, 1'b1));
        send(1, 8'h0A); send(1, 8'h40);
        expect_msg("t2_msg_b", pk(8'hB0, 8'h0A, 8'h40, 2'd2, 1'b1));

        // Simultaneous completion, stalled downstream, overflow on port 0
        msg_ready = 1'b0;
        send2(8'h90, 8'h80); send2(8'h40, 8'h41); send2(8'h7F, 8'h00);
        @(negedge CLOCK_25);
        chk("t3_first",  out_pk, pk(8'h90, 8'h40, 8'h7F, 2'd2, 1'b0));
        send(0, 8'h3C); send(0, 8'h11);
        chk("t3_no_ovf", {30'b0, ovf}, 32'd0);
        send(0, 8'h3D); send(0, 8'h12);
        chk("t3_ovf",    {30'b0, ovf}, 32'd1);
        idle(3);
        chk("t3_stable_v", {31'b0, msg_valid}, 32'd1);
        chk("t3_stable",   out_pk, pk(8'h90, 8'h40, 8'h7F, 2'd2, 1'b0));
        msg_ready = 1'b1;
        @(negedge CLOCK_25);
        expect_msg("t3_second", pk(8'h80, 8'h41, 8'h00, 2'd2, 1'b1));
        expect_msg("t3_held",   pk(8'h90, 8'h3C, 8'h11, 2'd2, 1'b0));

        // Real-time interleaved in a note message
        send(0, 8'h90); send(0, 8'hF8);
`ifdef MIDI_SYSRT_EN
        chk("t4_rt", rt_pk, {23'b0, 1'b1, 8'hF8});
`else
        chk("t4_rt", rt_pk, 32'd0);
`endif
        send(0, 8'h3C);
        chk("t4_rt_off", rt_pk, 32'd0);
        send(0, 8'h64);
        expect_msg("t4_msg", pk(8'h90, 8'h3C, 8'h64, 2'd2, 1'b0));

        // Both ports real-time together, then a third on port 1 into a full skid
        send2(8'hF8, 8'hF9);
`ifdef MIDI_SYSRT_EN
        chk("t4_skid_a", rt_pk, {23'b0, 1'b1, 8'hF8});
        send2(8'hFA, 8'hFB);
        chk("t4_skid_b", rt_pk, {23'b0, 1'b1, 8'hFA});
        @(negedge CLOCK_25);
        chk("t4_skid_c", rt_pk, {23'b0, 1'b1, 8'hF9});
        chk("t4_rt_ovf", {30'b0, ovf}, 32'd3);
        @(negedge CLOCK_25);
        chk("t4_skid_d", rt_pk, 32'd0);
`else
        chk("t4_skid_a", rt_pk, 32'd0);
        send2(8'hFA, 8'hFB);
        chk("t4_rt_ovf", {30'b0, ovf}, 32'd1);
`endif

        // Sysex clears running status; later program change
        send(0, 8'hF0); send(0, 8'h7E); send(0, 8'h01); send(0, 8'hF7); send(0, 8'h7F);
        idle(4);
        chk("t5_quiet", {31'b0, msg_valid}, 32'd0);
        send(0, 8'hC5); send(0, 8'h10);
        expect_msg("t5_prog", pk(8'hC5, 8'h10, 8'h00, 2'd1, 1'b0));

        // System common: F6 alone, F1 with one byte, neither keeps status
        send(1, 8'hF6);
        expect_msg("t6_f6", pk(8'hF6, 8'h00, 8'h00, 2'd0, 1'b1));
        send(1, 8'h05);
        idle(4);
        chk("t6_f6_nors", {31'b0, msg_valid}, 32'd0);
        send(1, 8'hF1); send(1, 8'h22);
        expect_msg("t6_f1", pk(8'hF1, 8'h22, 8'h00, 2'd1, 1'b1));
        send(1, 8'h33);
        idle(4);
        chk("t6_f1_nors", {31'b0, msg_valid}, 32'd0);

        // Reset during an offer with a partial message on port 1
        msg_ready = 1'b0;
        send(0, 8'hC0); send(0, 8'h05);
        send(1, 8'h90); send(1, 8'h30);
        chk("t7_offer", {31'b0, msg_valid}, 32'd1);
        iRST = 1'b1;
        @(negedge CLOCK_25);
        iRST = 1'b0;
        chk("t7_valid", {31'b0, msg_valid}, 32'd0);
        chk("t7_msg",   out_pk, 32'd0);
        chk("t7_ovf",   {30'b0, ovf}, 32'd0);
        chk("t7_rt",    rt_pk, 32'd0);
        msg_ready = 1'b1;
        send(1, 8'h40);
        idle(4);
        chk("t7_lone", {31'b0, msg_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
